backbone_j_collect: RTL
=======================

BACKBONE_J_COLLECT -- requirements
Module: backbone_j_collect

Interface
REQ-001 SHALL have parameter J, default 14, number of backbone slots per frame; legal range 2..64.
REQ-002 SHALL have localparam J_WIDTH = $clog2(J)+1, slot counter width.
REQ-003 SHALL have localparam SUM_WIDTH = 32+$clog2(J), signed sum width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port backbone  input  32  frame-start value, signed two's complement; becomes slot 0.
REQ-007 SHALL have port backbone_tvalid  input  1  one-cycle strobe qualifying backbone; starts a frame.
REQ-008 SHALL have port backbone_J_tvalid  input  1  strobe from the backbone_J generator stage.
REQ-009 SHALL have port backbone_J  input  32  generated value for slots 1..J-1, signed, in slot order.
REQ-010 SHALL have port err_clr  input  1  synchronous clear of sticky error flags.
REQ-011 SHALL have port backbone_vec  output  J*32  packed frame; slot k at bits [k*32 +: 32].
REQ-012 SHALL have port backbone_vec_tvalid  output  1  one-cycle pulse when backbone_vec holds a new complete frame.
REQ-013 SHALL have port backbone_sum  output  SUM_WIDTH  signed sum of all J slots of the last frame.
REQ-014 SHALL have port busy  output  1  high while a frame is being collected.
REQ-015 SHALL have port stray_err  output  1  sticky; backbone_J_tvalid seen outside a frame.
REQ-016 SHALL have port overrun_err  output  1  sticky; backbone_tvalid seen mid-frame.

Function
REQ-017 SHALL implement states IDLE, COLLECT, DONE.
REQ-018 IDLE + backbone_tvalid: write backbone to staging slot 0, slot counter = 1, go to COLLECT.
REQ-019 COLLECT + backbone_J_tvalid: write backbone_J to staging slot[counter], then counter + 1.
REQ-020 COLLECT: the write to slot J-1 SHALL transition the state to DONE.
REQ-021 DONE: for exactly one cycle, copy staging to backbone_vec, assert backbone_vec_tvalid, then go to IDLE.
REQ-022 Latency from the clk edge capturing slot J-1 to the backbone_vec_tvalid high cycle SHALL be 1 cycle.
REQ-023 backbone_vec and backbone_sum SHALL hold their values until the next DONE; staging writes SHALL NOT disturb them.
REQ-024 busy SHALL be high in COLLECT and DONE and low in IDLE.
REQ-025 backbone_J_tvalid in IDLE: drop the sample and set stray_err.
REQ-026 backbone_tvalid in COLLECT: ignore it, keep the current frame, set overrun_err.
REQ-027 DONE + backbone_tvalid in the same cycle: accept it as slot 0 of a new frame, go to COLLECT with counter = 1; no lost strobe.
REQ-028 DONE + backbone_J_tvalid in the same cycle: treat it as stray (REQ-025).
REQ-029 err_clr SHALL clear both sticky flags; if an error event occurs in the same cycle, the set wins.
REQ-030 No backpressure: inputs are never stalled and there is no ready signal.

Reset
REQ-031 rst_n low SHALL force IDLE, counter = 0, all staging slots = 0, and backbone_vec = 0.
REQ-032 rst_n low SHALL force backbone_sum = 0, backbone_vec_tvalid = 0, busy = 0, stray_err = 0, overrun_err = 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; no backbone_vec_tvalid for it.

Configuration
REQ-034 Macro BACKBONE_J_SUM_EN defined: keep a running signed accumulator, sign-extended, per frame.
REQ-035 The accumulator SHALL load on slot 0, add on each slot write, and be copied to backbone_sum in DONE.
REQ-036 Macro BACKBONE_J_SUM_EN undefined: no accumulator logic; backbone_sum tied to 0.

Structure
REQ-037 State encodings (IDLE=2'b00, COLLECT=2'b01, DONE=2'b10) SHALL live in shared package backbone_pkg.
REQ-038 The 32-bit slot width constant SHALL also live in backbone_pkg.
REQ-039 One sub-module, backbone_sum_acc (signed accumulate, load/add/clear), SHALL exist; it is instantiated only under BACKBONE_J_SUM_EN.

Verification
REQ-040 J=4: backbone=0x100, then backbone_J=1,2,3 on nonconsecutive cycles -> backbone_vec={3,2,1,0x100}, one pulse, sum=0x106.
REQ-041 backbone_J_tvalid with no prior backbone_tvalid -> stray_err=1, no vec pulse; err_clr -> 0.
REQ-042 backbone_tvalid after 2 samples -> overrun_err=1; frame still completes with the original slot 0.
REQ-043 backbone_tvalid in the DONE cycle -> pulse for frame A; frame B completes with its own slot 0.
REQ-044 rst_n low after 2 samples -> all outputs 0; the next full frame completes normally.
REQ-045 Negative values -1,-1,-1,-1 (J=4) -> sum=-4 sign-extended; with the macro undefined, sum=0.

Source files
------------

// File: rtl/backbone_pkg.sv
//------------------------------------------------------------------------------
// Module   : backbone_pkg
// Purpose  : Shared slot width and collector state encodings.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package backbone_pkg;

  // Width of one backbone slot (signed two's complement)
  localparam int SLOT_W = 32;

  // Frame collector states
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    DONE    = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/backbone_sum_acc.sv
//------------------------------------------------------------------------------
// Module   : backbone_sum_acc
// Purpose  : Signed running accumulator with clear / load / add controls.
//            Exposes the next-state value so the parent can capture the
//            final sum on the same edge as the last slot write.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module backbone_sum_acc
  import backbone_pkg::*;
#(
  parameter int SUM_W = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic                    add_i,
  input  logic [SLOT_W-1:0]       din_i,
  output logic signed [SUM_W-1:0] acc_nxt_o
);

  logic signed [SUM_W-1:0] acc_q;
  logic signed [SUM_W-1:0] acc_d;
  logic signed [SUM_W-1:0] w_din_ext;

  assign w_din_ext = {{(SUM_W-SLOT_W){din_i[SLOT_W-1]}}, din_i};

  // Next accumulator value: clear beats load beats add
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = w_din_ext;
    end else if (add_i) begin
      acc_d = acc_q + w_din_ext;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_nxt_o = acc_d;

endmodule

`default_nettype wire

// File: rtl/backbone_j_collect.sv
//------------------------------------------------------------------------------
// Module   : backbone_j_collect
// Purpose  : Collects one backbone value plus J-1 generated backbone_J values
//            into a packed J-slot frame, with optional signed frame sum.
//            Optional feature macro: BACKBONE_J_SUM_EN (running sum).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module backbone_j_collect
  import backbone_pkg::*;
#(
  parameter  int J         = 14,
  localparam int J_WIDTH   = $clog2(J) + 1,
  localparam int SUM_WIDTH = 32 + $clog2(J)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SLOT_W-1:0]      backbone,
  input  logic                   backbone_tvalid,
  input  logic                   backbone_J_tvalid,
  input  logic [SLOT_W-1:0]      backbone_J,
  input  logic                   err_clr,
  output logic [J*SLOT_W-1:0]    backbone_vec,
  output logic                   backbone_vec_tvalid,
  output logic [SUM_WIDTH-1:0]   backbone_sum,
  output logic                   busy,
  output logic                   stray_err,
  output logic                   overrun_err
);

  state_t                    state_q, state_d;
  logic [J_WIDTH-1:0]        cnt_q, cnt_d;
  logic [J-1:0][SLOT_W-1:0]  stage_q, stage_d;
  logic [J*SLOT_W-1:0]       vec_q, vec_d;
  logic                      stray_q, stray_d;
  logic                      overrun_q, overrun_d;
  logic                      w_last;

  // Next-state, slot staging and frame-complete detection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    w_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (backbone_tvalid) begin
          stage_d[0] = backbone;
          cnt_d      = J_WIDTH'(1);
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (backbone_J_tvalid) begin
          for (int k = 1; k < J; k++) begin
            if (cnt_q == J_WIDTH'(k)) begin
              stage_d[k] = backbone_J;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == J_WIDTH'(J - 1)) begin
            w_last  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // A new frame start in the publish cycle is accepted, never lost
        if (backbone_tvalid) begin
          stage_d[0] = backbone;
          cnt_d      = J_WIDTH'(1);
          state_d    = COLLECT;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Output frame is loaded on the last-slot edge so it is valid in DONE
    vec_d = w_last ? stage_d : vec_q;
  end

  // Sticky error flags: a new event in the clear cycle wins
  always_comb begin
    stray_d   = (stray_q & ~err_clr) | (backbone_J_tvalid & (state_q != COLLECT));
    overrun_d = (overrun_q & ~err_clr) | (backbone_tvalid & (state_q == COLLECT));
  end

  // State, staging, published frame and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stage_q   <= '0;
      vec_q     <= '0;
      stray_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      vec_q     <= vec_d;
      stray_q   <= stray_d;
      overrun_q <= overrun_d;
    end
  end

  assign backbone_vec        = vec_q;
  assign backbone_vec_tvalid = (state_q == DONE);
  assign busy                = (state_q != IDLE);
  assign stray_err           = stray_q;
  assign overrun_err         = overrun_q;

`ifdef BACKBONE_J_SUM_EN
  logic                        w_acc_load;
  logic                        w_acc_add;
  logic                        w_acc_clr;
  logic [SLOT_W-1:0]           w_acc_din;
  logic signed [SUM_WIDTH-1:0] w_acc_nxt;
  logic [SUM_WIDTH-1:0]        sum_q;

  assign w_acc_load = backbone_tvalid & ((state_q == IDLE) | (state_q == DONE));
  assign w_acc_add  = backbone_J_tvalid & (state_q == COLLECT);
  assign w_acc_clr  = (state_q == DONE) & ~backbone_tvalid;
  assign w_acc_din  = w_acc_load ? backbone : backbone_J;

  backbone_sum_acc #(
    .SUM_W     (SUM_WIDTH)
  ) u_sum_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (w_acc_clr),
    .load_i    (w_acc_load),
    .add_i     (w_acc_add),
    .din_i     (w_acc_din),
    .acc_nxt_o (w_acc_nxt)
  );

  // Published sum follows the published frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (w_last) begin
      sum_q <= w_acc_nxt;
    end
  end

  assign backbone_sum = sum_q;
`else
  assign backbone_sum = '0;
`endif

endmodule

`default_nettype wire
